// File: rtl/gcn_pkg.sv
// Shared phase encoding for the GCN phase sequencer and any monitors.
package gcn_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TRANS  = 3'd1,
        COMB   = 3'd2,
        ARGMAX = 3'd3,
        DONE   = 3'd4
    } phase_t;

endpackage

// File: rtl/gcn_wrap_counter.sv
// Modulo-MAX up counter with synchronous clear; last flags the value MAX-1.
module gcn_wrap_counter #(
    parameter int unsigned MAX = 6,
    parameter int unsigned W   = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         last
);

    localparam logic [W-1:0] LAST_VAL = W'(MAX - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST_VAL) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_VAL);

endmodule

// File: rtl/gcn_phase_sequencer.sv
// GCN phase controller: TRANS -> COMB edge stream -> ARGMAX row scan -> DONE.
// Optional busy-cycle counter port cycle_count when GCN_SEQ_PERF_EN is defined.
module gcn_phase_sequencer
    import gcn_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS    = 6,
    parameter int unsigned COO_NUM_OF_COLS = 6,
    parameter int unsigned COO_BW          = (COO_NUM_OF_COLS > 1) ? $clog2(COO_NUM_OF_COLS) : 1,
    parameter int unsigned ROW_BW          = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              done_trans,
    input  logic              comb_ready,
    output logic              trans_start,
    output logic [COO_BW-1:0] coo_address,
    output logic              edge_valid,
    output logic [ROW_BW-1:0] row_select,
    output logic              argmax_valid,
    output logic              busy,
    output logic [2:0]        phase,
    output logic              done
`ifdef GCN_SEQ_PERF_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    phase_t state_q, state_d;
    logic   trans_start_q, trans_start_d;
    logic   edge_valid_q, edge_valid_d;
    logic   argmax_valid_q, argmax_valid_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic   edge_adv;
    logic   coo_last;
    logic   row_last;

    assign edge_adv = edge_valid_q & comb_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = TRANS;
            TRANS:   if (done_trans) state_d = COMB;
            COMB:    if (edge_adv && coo_last) state_d = ARGMAX;
            ARGMAX:  if (row_last) state_d = DONE;
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered
        // in the same cycle the state register reflects the new phase.
        trans_start_d  = (state_q == IDLE) && start;
        edge_valid_d   = (state_d == COMB);
        argmax_valid_d = (state_d == ARGMAX);
        busy_d         = (state_d == TRANS) || (state_d == COMB) || (state_d == ARGMAX);
        done_d         = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            trans_start_q  <= 1'b0;
            edge_valid_q   <= 1'b0;
            argmax_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            trans_start_q  <= trans_start_d;
            edge_valid_q   <= edge_valid_d;
            argmax_valid_q <= argmax_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    gcn_wrap_counter #(
        .MAX (COO_NUM_OF_COLS),
        .W   (COO_BW)
    ) u_coo_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (edge_adv),
        .clr   (trans_start_d),
        .count (coo_address),
        .last  (coo_last)
    );

    gcn_wrap_counter #(
        .MAX (FEATURE_ROWS),
        .W   (ROW_BW)
    ) u_row_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (argmax_valid_q),
        .clr   (trans_start_d),
        .count (row_select),
        .last  (row_last)
    );

`ifdef GCN_SEQ_PERF_EN
    logic [31:0] cycle_count_q, cycle_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (trans_start_d) begin
            cycle_count_d = '0;
        end else if (busy_q && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
`endif

    assign trans_start  = trans_start_q;
    assign edge_valid   = edge_valid_q;
    assign argmax_valid = argmax_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign phase        = state_q;

endmodule

// File: tb/tb_gcn_phase_sequencer.sv
// Directed bench for gcn_phase_sequencer; covers cycle_count when GCN_SEQ_PERF_EN is defined.
module tb_gcn_phase_sequencer;
    import gcn_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done_trans;
    logic       comb_ready;
    logic       trans_start;
    logic [2:0] coo_address;
    logic       edge_valid;
    logic [2:0] row_select;
    logic       argmax_valid;
    logic       busy;
    logic [2:0] phase;
    logic       done;
`ifdef GCN_SEQ_PERF_EN
    logic [31:0] cycle_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gcn_phase_sequencer #(
        .FEATURE_ROWS    (6),
        .COO_NUM_OF_COLS (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .done_trans   (done_trans),
        .comb_ready   (comb_ready),
        .trans_start  (trans_start),
        .coo_address  (coo_address),
        .edge_valid   (edge_valid),
        .row_select   (row_select),
        .argmax_valid (argmax_valid),
        .busy         (busy),
        .phase        (phase),
        .done         (done)
`ifdef GCN_SEQ_PERF_EN
        ,
        .cycle_count  (cycle_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {trans_start, edge_valid, argmax_valid, busy, done, phase, coo_address, row_select}
    function automatic logic [13:0] obs_vec();
        return {trans_start, edge_valid, argmax_valid, busy, done, phase, coo_address, row_select};
    endfunction

    // Expected outputs n cycles after the edge that sampled start, for a run with
    // done_trans in cycle 5 and a comb_ready stall of s cycles at address 2.
    function automatic logic [13:0] exp_vec(input int n, input int s);
        logic [13:0] v;
        int j;
        int a;
        v = '0;
        if (n <= 5) begin
            v[13]  = (n == 1);
            v[10]  = 1'b1;
            v[8:6] = TRANS;
        end else if (n <= 11 + s) begin
            j = n - 6;
            a = (j < 2) ? j : ((j <= 2 + s) ? 2 : j - s);
            v[12]  = 1'b1;
            v[10]  = 1'b1;
            v[8:6] = COMB;
            v[5:3] = 3'(a);
        end else if (n <= 17 + s) begin
            v[11]  = 1'b1;
            v[10]  = 1'b1;
            v[8:6] = ARGMAX;
            v[2:0] = 3'(n - 12 - s);
        end else begin
            v[9]   = 1'b1;
            v[8:6] = DONE;
        end
        return v;
    endfunction

    task automatic drive_run(input string tag, input int s, input bit hold);
        logic [13:0] e;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int n = 1; n <= 18 + s; n++) begin
            e = exp_vec(n, s);
            n_cmp++;
            if (obs_vec() !== e) begin
                n_bad++;
                $display("FAIL %s cyc=%0d outs got=%b want=%b", tag, n, obs_vec(), e);
            end
`ifdef GCN_SEQ_PERF_EN
            n_cmp++;
            if (cycle_count !== 32'(n - 1)) begin
                n_bad++;
                $display("FAIL %s cyc=%0d cycle_count got=%0d want=%0d", tag, n, cycle_count, n - 1);
            end
`endif
            done_trans = (n == 5);
            comb_ready = !(s > 0 && n >= 8 && n < 8 + s);
            if (n < 18 + s) tick();
        end
        done_trans = 1'b0;
        comb_ready = 1'b1;
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                done_trans = (k % 2) == 0;
                comb_ready = (k % 2) != 0;
                tick();
                e = exp_vec(18 + s, s);
                n_cmp++;
                if (obs_vec() !== e) begin
                    n_bad++;
                    $display("FAIL %s done_hold k=%0d got=%b want=%b", tag, k, obs_vec(), e);
                end
            end
            done_trans = 1'b0;
            comb_ready = 1'b1;
            start = 1'b0;
        end
        tick();
        n_cmp++;
        if (obs_vec() !== 14'b0) begin
            n_bad++;
            $display("FAIL %s back_to_idle got=%b want=%b", tag, obs_vec(), 14'b0);
        end
`ifdef GCN_SEQ_PERF_EN
        n_cmp++;
        if (cycle_count !== 32'(17 + s)) begin
            n_bad++;
            $display("FAIL %s frozen cycle_count got=%0d want=%0d", tag, cycle_count, 17 + s);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        done_trans = 1'b0;
        comb_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (obs_vec() !== 14'b0) begin
            n_bad++;
            $display("FAIL reset_state got=%b want=%b", obs_vec(), 14'b0);
        end
`ifdef GCN_SEQ_PERF_EN
        n_cmp++;
        if (cycle_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_cycle_count got=%0d want=0", cycle_count);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_idle_noise();
        for (int k = 0; k < 4; k++) begin
            done_trans = k[0];
            comb_ready = k[1];
            tick();
            n_cmp++;
            if (obs_vec() !== 14'b0) begin
                n_bad++;
                $display("FAIL idle_noise k=%0d got=%b want=%b", k, obs_vec(), 14'b0);
            end
        end
        done_trans = 1'b0;
        comb_ready = 1'b1;
    endtask

    task automatic test_nominal();
        drive_run("nominal", 0, 1'b0);
    endtask

    task automatic test_stall();
        drive_run("stall", 3, 1'b0);
    endtask

    task automatic test_start_held();
        drive_run("start_held", 0, 1'b1);
    endtask

    task automatic test_reset_mid_comb();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 9; n++) begin
            done_trans = (n == 5);
            tick();
        end
        done_trans = 1'b0;
        n_cmp++;
        if (obs_vec() !== exp_vec(9, 0)) begin
            n_bad++;
            $display("FAIL pre_reset_comb got=%b want=%b", obs_vec(), exp_vec(9, 0));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (obs_vec() !== 14'b0) begin
            n_bad++;
            $display("FAIL mid_reset got=%b want=%b", obs_vec(), 14'b0);
        end
        tick();
        n_cmp++;
        if (obs_vec() !== 14'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle got=%b want=%b", obs_vec(), 14'b0);
        end
        drive_run("after_reset", 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive_run("rerun", 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle_noise();
        test_nominal();
        test_stall();
        test_start_held();
        test_reset_mid_comb();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
